imem_boot: RTL and testbench

//  Instruction memory with a built-in byte-stream boot loader; sits directly upstream of core's i_mem port.

---
 rtl/imem_boot_if.sv | 20 ++
 rtl/imem_boot.sv | 183 ++++++++++++++++++
 tb/tb_imem_boot.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_if.sv
// Boot-stream and instruction-fetch bundle for imem_boot.
// master: the side that supplies boot bytes and fetch addresses (testbench / SoC glue + core).
// slave : the instruction memory with its loader.
interface imem_boot_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] i_mem_r_addr;
    logic [31:0] i_mem_r_data;

    modport master (
        output rx_data, rx_valid, i_mem_r_addr,
        input  rx_ready, i_mem_r_data
    );

    modport slave (
        input  rx_data, rx_valid, i_mem_r_addr,
        output rx_ready, i_mem_r_data
    );
endinterface

// File: rtl/imem_boot.sv
// Instruction memory with a byte-stream boot loader.
// A length-prefixed program (N[15:8], N[7:0], N big-endian words) is written into a
// word RAM while the core is held in reset; the core is released RST_HOLD cycles
// after the last accepted byte. The fetch port is a combinational read that is
// always live and wraps on the word index.
// Optional feature: define IMEM_BOOT_CHECKSUM_EN to require a trailing XOR checksum
// byte over all data bytes (header excluded).
module imem_boot #(
    parameter int MEM_SIZE = 1024,
    parameter int RST_HOLD = 6
) (
    input  logic        clk,
    input  logic        rst,
    imem_boot_if.slave  bus,
    input  logic        reload,
    output logic        core_rst,
    output logic        done,
    output logic        error,
    output logic [15:0] load_count
);
    localparam int AW = $clog2(MEM_SIZE);

    typedef enum logic [2:0] {
        S_HDR, S_DATA, S_CSUM, S_HOLD, S_RUN, S_ERR
    } state_t;

`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam state_t AFTER_DATA = S_CSUM;
`else
    localparam state_t AFTER_DATA = S_HOLD;
`endif

    logic [31:0] mem [MEM_SIZE];

    state_t      state_q, state_d;
    logic        hdr_cnt_q, hdr_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] load_cnt_q, load_cnt_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] n_q, n_d;
    logic [23:0] asm_q, asm_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic          xfer;
    logic [15:0]   hdr_n;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          unused_addr_bits;

    assign bus.rx_ready = ~rst & ((state_q == S_HDR) | (state_q == S_DATA) | (state_q == S_CSUM));
    assign xfer         = bus.rx_valid & bus.rx_ready;
    assign hdr_n        = {n_q[15:8], bus.rx_data};

    assign core_rst   = (state_q != S_RUN);
    assign done       = (state_q == S_RUN);
    assign error      = (state_q == S_ERR);
    assign load_count = load_cnt_q;

    // Fetch port: word index taken from the byte address, upper bits ignored so reads wrap.
    assign bus.i_mem_r_data = mem[bus.i_mem_r_addr[AW+1:2]];
    assign unused_addr_bits = ^{bus.i_mem_r_addr[31:AW+2], bus.i_mem_r_addr[1:0]};

    // Next-state and datapath decode for the loader FSM.
    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        byte_cnt_d = byte_cnt_q;
        load_cnt_d = load_cnt_q;
        hold_d     = hold_q;
        n_d        = n_q;
        asm_d      = asm_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        we         = 1'b0;
        waddr      = load_cnt_q[AW-1:0];
        wdata      = {asm_q, bus.rx_data};

        case (state_q)
            S_HDR: begin
                if (xfer) begin
                    if (!hdr_cnt_q) begin
                        n_d[15:8] = bus.rx_data;
                        hdr_cnt_d = 1'b1;
                    end else begin
                        n_d       = hdr_n;
                        hdr_cnt_d = 1'b0;
                        hold_d    = '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        csum_d    = 8'h00;
`endif
                        if ({16'b0, hdr_n} > 32'(MEM_SIZE)) begin
                            state_d = S_ERR;
                        end else if (hdr_n == 16'd0) begin
                            state_d = AFTER_DATA;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                    csum_d = csum_q ^ bus.rx_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        we         = 1'b1;
                        load_cnt_d = load_cnt_q + 16'd1;
                        byte_cnt_d = 2'd0;
                        if (load_cnt_q + 16'd1 == n_q) begin
                            state_d = AFTER_DATA;
                            hold_d  = '0;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        asm_d      = {asm_q[15:0], bus.rx_data};
                    end
                end
            end
            S_CSUM: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                if (xfer) begin
                    hold_d  = '0;
                    state_d = (bus.rx_data == csum_q) ? S_HOLD : S_ERR;
                end
`endif
            end
            S_HOLD: begin
                if (hold_q == 16'(RST_HOLD - 1)) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q + 16'd1;
                end
            end
            S_RUN, S_ERR: begin
                if (reload) begin
                    state_d    = S_HDR;
                    hdr_cnt_d  = 1'b0;
                    byte_cnt_d = 2'd0;
                    load_cnt_d = '0;
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HDR;
            hdr_cnt_q  <= 1'b0;
            byte_cnt_q <= 2'd0;
            load_cnt_q <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            load_cnt_q <= load_cnt_d;
            hold_q     <= hold_d;
        end
    end

    // Header/assembly/checksum data registers; always rewritten before use, so no reset.
    always_ff @(posedge clk) begin
        n_q    <= n_d;
        asm_q  <= asm_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
        csum_q <= csum_d;
`endif
    end

    // RAM write port; contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end
endmodule

// File: tb/tb_imem_boot.sv
// Testbench for imem_boot: randomized boot loads checked against a byte-stream model.
`timescale 1ns/1ps
module tb_imem_boot;
    localparam int MEM_SIZE = 1024;
    localparam int RST_HOLD = 6;
`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef logic [7:0]  byte_q_t [$];
    typedef logic [31:0] word_q_t [$];

    logic        clk = 1'b0;
    logic        rst;
    logic        reload;
    logic        core_rst, done, error;
    logic [15:0] load_count;

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;

    logic [31:0] ref_mem [MEM_SIZE];

    imem_boot_if bus();

    imem_boot #(.MEM_SIZE(MEM_SIZE), .RST_HOLD(RST_HOLD)) dut (
        .clk(clk), .rst(rst), .bus(bus), .reload(reload),
        .core_rst(core_rst), .done(done), .error(error), .load_count(load_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog sim_time=%0t limit=1000000", $time);
        $fatal(1, "watchdog expired");
    end

    // Stream image: header, big-endian words, optional XOR checksum.
    function automatic byte_q_t build_stream(input word_q_t w, input logic [15:0] n, input bit with_csum);
        byte_q_t     b;
        logic [7:0]  x;
        logic [31:0] wd;
        x = 8'h00;
        b.push_back(n[15:8]);
        b.push_back(n[7:0]);
        foreach (w[i]) begin
            wd = w[i];
            for (int k = 3; k >= 0; k--) begin
                b.push_back(wd[8*k +: 8]);
                x = x ^ wd[8*k +: 8];
            end
        end
        if (with_csum) b.push_back(x);
        return b;
    endfunction

    task automatic model_load(input word_q_t w);
        foreach (w[i]) ref_mem[i] = w[i];
    endtask

    // gap_mode: 0 = valid held high, 1 = valid low on alternate cycles, 2 = random gaps.
    task automatic send_bytes(input byte_q_t b, input int gap_mode, output int last_edge);
        int i = 0;
        int guard = 0;
        bit v;
        bit alt = 1'b0;
        bit saw_low = 1'b0;
        last_edge = -1;
        while (i < b.size() && guard < 20000) begin
            @(negedge clk);
            case (gap_mode)
                0:       v = 1'b1;
                1:       begin v = alt; alt = ~alt; end
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            bus.rx_valid = v;
            bus.rx_data  = v ? b[i] : 8'($urandom);
            #1;
            if (core_rst !== 1'b1) saw_low = 1'b1;
            if (v && bus.rx_ready === 1'b1) begin
                i++;
                last_edge = cyc + 1;
            end
            guard++;
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        n_vec++;
        if (i < b.size()) begin
            n_err++;
            $display("FAIL stream_accept got=%0d bytes exp=%0d bytes", i, b.size());
        end
        n_vec++;
        if (saw_low) begin
            n_err++;
            $display("FAIL core_rst_during_load got=0 exp=1");
        end
    endtask

    task automatic wait_release(output int fall_edge);
        fall_edge = -1;
        for (int t = 0; t < 400; t++) begin
            if (core_rst === 1'b0) begin
                fall_edge = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic fetch(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.i_mem_r_addr = a;
        #1;
        d = bus.i_mem_r_data;
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        bus.rx_valid = 1'b1;
        #1;
        n_vec++; if (bus.rx_ready !== 1'b0) begin n_err++; $display("FAIL reset_rx_ready got=%b exp=0", bus.rx_ready); end
        n_vec++; if (core_rst !== 1'b1) begin n_err++; $display("FAIL reset_core_rst got=%b exp=1", core_rst); end
        n_vec++; if (done !== 1'b0 || error !== 1'b0) begin n_err++; $display("FAIL reset_flags got=%b%b exp=00", done, error); end
        n_vec++; if (load_count !== 16'd0) begin n_err++; $display("FAIL reset_load_count got=%0d exp=0", load_count); end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_vec++; if (bus.rx_ready !== 1'b1) begin n_err++; $display("FAIL hdr_rx_ready got=%b exp=1", bus.rx_ready); end
    endtask

    task automatic test_basic(input int gap_mode);
        word_q_t     w;
        int          last, fall;
        logic [31:0] d;
        logic [31:0] addrs [4];
        logic [31:0] exps  [4];
        w.push_back(32'h01234567);
        w.push_back(32'h89ABCDEF);
        send_bytes(build_stream(w, 16'd2, CSUM_EN), gap_mode, last);
        wait_release(fall);
        model_load(w);
        n_vec++; if (fall !== last + RST_HOLD) begin n_err++; $display("FAIL basic%0d_release_edge got=%0d exp=%0d", gap_mode, fall, last + RST_HOLD); end
        n_vec++; if (done !== 1'b1 || error !== 1'b0) begin n_err++; $display("FAIL basic%0d_flags got=%b%b exp=10", gap_mode, done, error); end
        n_vec++; if (load_count !== 16'd2) begin n_err++; $display("FAIL basic%0d_load_count got=%0d exp=2", gap_mode, load_count); end
        n_vec++; if (bus.rx_ready !== 1'b0) begin n_err++; $display("FAIL basic%0d_run_rx_ready got=%b exp=0", gap_mode, bus.rx_ready); end
        addrs[0] = 32'h0;                       exps[0] = 32'h01234567;
        addrs[1] = 32'h4;                       exps[1] = 32'h89ABCDEF;
        addrs[2] = 32'h4 + 32'(MEM_SIZE) * 4;   exps[2] = 32'h89ABCDEF;
        addrs[3] = 32'hFFFF_F003;               exps[3] = 32'h01234567;
        for (int i = 0; i < 4; i++) begin
            fetch(addrs[i], d);
            n_vec++;
            if (d !== exps[i]) begin n_err++; $display("FAIL basic%0d_fetch addr=%h got=%h exp=%h", gap_mode, addrs[i], d, exps[i]); end
        end
    endtask

    task automatic test_reload_in_run();
        pulse_reload();
        #1;
        n_vec++; if (core_rst !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL reload_run got core_rst=%b done=%b exp 1 0", core_rst, done); end
        n_vec++; if (load_count !== 16'd0) begin n_err++; $display("FAIL reload_load_count got=%0d exp=0", load_count); end
        n_vec++; if (bus.rx_ready !== 1'b1) begin n_err++; $display("FAIL reload_rx_ready got=%b exp=1", bus.rx_ready); end
    endtask

    task automatic test_empty();
        word_q_t     w;
        int          last, fall;
        logic [31:0] d;
        send_bytes(build_stream(w, 16'd0, CSUM_EN), 0, last);
        wait_release(fall);
        n_vec++; if (fall !== last + RST_HOLD) begin n_err++; $display("FAIL empty_release_edge got=%0d exp=%0d", fall, last + RST_HOLD); end
        n_vec++; if (load_count !== 16'd0) begin n_err++; $display("FAIL empty_load_count got=%0d exp=0", load_count); end
        for (int i = 0; i < 2; i++) begin
            fetch(32'(i) * 4, d);
            n_vec++;
            if (d !== ref_mem[i]) begin n_err++; $display("FAIL empty_ram_kept idx=%0d got=%h exp=%h", i, d, ref_mem[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] hdrs [2];
        byte_q_t     b;
        int          last;
        hdrs[0] = 16'h0401;
        hdrs[1] = 16'($urandom_range(MEM_SIZE + 1, 65535));
        for (int j = 0; j < 2; j++) begin
            b.delete();
            b.push_back(hdrs[j][15:8]);
            b.push_back(hdrs[j][7:0]);
            send_bytes(b, 2, last);
            repeat (RST_HOLD + 3) @(negedge clk);
            #1;
            n_vec++; if (error !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL ovf_flags n=%0d got=%b%b exp=01", hdrs[j], error, done); end
            n_vec++; if (bus.rx_ready !== 1'b0) begin n_err++; $display("FAIL ovf_rx_ready n=%0d got=%b exp=0", hdrs[j], bus.rx_ready); end
            n_vec++; if (core_rst !== 1'b1) begin n_err++; $display("FAIL ovf_core_rst n=%0d got=%b exp=1", hdrs[j], core_rst); end
            pulse_reload();
            #1;
            n_vec++; if (error !== 1'b0 || bus.rx_ready !== 1'b1 || core_rst !== 1'b1) begin
                n_err++; $display("FAIL ovf_reload got error=%b rx_ready=%b core_rst=%b exp 0 1 1", error, bus.rx_ready, core_rst);
            end
        end
    endtask

    task automatic test_rst_midload();
        word_q_t     w;
        byte_q_t     b;
        int          last;
        logic [31:0] r, d;
        r = $urandom();
        w.push_back(r);
        w.push_back(32'h0);
        w.push_back(32'h0);
        b = build_stream(w, 16'd3, 1'b0);
        while (b.size() > 7) b.pop_back();
        send_bytes(b, 2, last);
        ref_mem[0] = r;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++; if (load_count !== 16'd0 || core_rst !== 1'b1) begin n_err++; $display("FAIL midrst_state got count=%0d core_rst=%b exp 0 1", load_count, core_rst); end
        n_vec++; if (bus.rx_ready !== 1'b1) begin n_err++; $display("FAIL midrst_rx_ready got=%b exp=1", bus.rx_ready); end
        fetch(32'h0, d);
        n_vec++; if (d !== r) begin n_err++; $display("FAIL midrst_word_kept got=%h exp=%h", d, r); end
        test_basic(2);
        test_reload_in_run();
    endtask

    task automatic test_random();
        word_q_t     w;
        int          last, fall, n;
        logic [31:0] a, d;
        for (int it = 0; it < 6; it++) begin
            n = (it == 5) ? MEM_SIZE : $urandom_range(1, 48);
            pulse_reload();
            w.delete();
            for (int k = 0; k < n; k++) w.push_back($urandom());
            send_bytes(build_stream(w, 16'(n), CSUM_EN), (it == 5) ? 0 : 2, last);
            wait_release(fall);
            model_load(w);
            n_vec++; if (fall !== last + RST_HOLD) begin n_err++; $display("FAIL rand_release_edge n=%0d got=%0d exp=%0d", n, fall, last + RST_HOLD); end
            n_vec++; if (load_count !== 16'(n) || done !== 1'b1) begin n_err++; $display("FAIL rand_count n=%0d got=%0d done=%b exp=%0d 1", n, load_count, done, n); end
            for (int i = 0; i < n; i++) begin
                a = ($urandom() & ~(32'(MEM_SIZE) * 4 - 1)) | (32'(i) << 2) | 32'($urandom_range(0, 3));
                fetch(a, d);
                n_vec++;
                if (d !== ref_mem[i]) begin n_err++; $display("FAIL rand_fetch addr=%h got=%h exp=%h", a, d, ref_mem[i]); end
            end
        end
    endtask

`ifdef IMEM_BOOT_CHECKSUM_EN
    task automatic test_checksum();
        word_q_t w;
        byte_q_t b;
        int      last, fall;
        w.push_back(32'h01234567);
        w.push_back(32'h89ABCDEF);
        pulse_reload();
        b = build_stream(w, 16'd2, 1'b1);
        send_bytes(b, 0, last);
        wait_release(fall);
        n_vec++; if (fall !== last + RST_HOLD || done !== 1'b1) begin n_err++; $display("FAIL csum_good got edge=%0d done=%b exp=%0d 1", fall, done, last + RST_HOLD); end
        pulse_reload();
        b[b.size() - 1] = b[b.size() - 1] ^ 8'h01;
        send_bytes(b, 2, last);
        repeat (RST_HOLD + 3) @(negedge clk);
        #1;
        n_vec++; if (error !== 1'b1 || core_rst !== 1'b1) begin n_err++; $display("FAIL csum_bad got error=%b core_rst=%b exp 1 1", error, core_rst); end
        pulse_reload();
    endtask
`endif

    initial begin
        rst              = 1'b1;
        reload           = 1'b0;
        bus.rx_valid     = 1'b0;
        bus.rx_data      = 8'h00;
        bus.i_mem_r_addr = 32'h0;
        test_reset();
        test_basic(0);
        test_reload_in_run();
        test_basic(1);
        pulse_reload();
        test_empty();
        pulse_reload();
        test_overflow();
        test_rst_midload();
        test_random();
`ifdef IMEM_BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
